pic_host_master: RTL and testbench

PIC_HOST_MASTER -- requirements
Module: pic_host_master

---
 rtl/pic_host_master_if.sv | 26 ++
 rtl/pic_host_master.sv | 157 +++++++++++++++
 tb/tb_pic_host_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_host_master_if.sv
// Host-side command, response and vector handshake of pic_host_master.
// The DUT connects to the master modport; the host side connects to the slave modport.
interface pic_host_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rd;
   logic       cmd_a0;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       ack_en;
   logic       vec_valid;
   logic [7:0] vec_data;
   logic       vec_spurious;
   logic       busy;

   modport master (
      input  cmd_valid, cmd_rd, cmd_a0, cmd_data, ack_en,
      output cmd_ready, rsp_valid, rsp_data, vec_valid, vec_data, vec_spurious, busy
   );

   modport slave (
      output cmd_valid, cmd_rd, cmd_a0, cmd_data, ack_en,
      input  cmd_ready, rsp_valid, rsp_data, vec_valid, vec_data, vec_spurious, busy
   );
endinterface

// File: rtl/pic_host_master.sv
// Bus master for an 8259-style PIC: register read/write accesses and automatic INTA cycles.
// Optional macro SPURIOUS_DET_EN adds spurious-interrupt flagging on vec_spurious.
module pic_host_master #(
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned GAP_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pic_host_master_if.master     host,
   input  logic                  INT_Flag,
   output logic                  chip_select,
   output logic                  read_flag,
   output logic                  write_flag,
   output logic                  A0,
   output logic                  INTA,
   inout  wire  [7:0]            data_Bus
);

   localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int unsigned CW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] RD      = 3'd2;
   localparam logic [2:0] RECOVER = 3'd3;
   localparam logic [2:0] ACK1    = 3'd4;
   localparam logic [2:0] GAP     = 3'd5;
   localparam logic [2:0] ACK2    = 3'd6;
   localparam logic [2:0] DONE    = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sync_q;
   logic          int_s, armed_q;
   logic          rd_q, a0_q;
   logic [7:0]    wdata_q, rsp_data_q, vec_data_q;
   logic          cs_q, rd_n_q, wr_n_q, inta_q, drv_q;
   logic          rsp_valid_q, vec_valid_q, busy_q;
   logic          start_ack, accept, pulse_last, gap_last;

   assign int_s      = sync_q[1];
   assign start_ack  = (state_q == IDLE) && host.ack_en && int_s && armed_q;
   // Gated by rst_n so the combinational ready reads 0 while reset is held.
   assign host.cmd_ready = rst_n && (state_q == IDLE) && !start_ack;
   assign accept     = host.cmd_valid && host.cmd_ready;
   assign pulse_last = (cnt_q == PULSE_LAST);
   assign gap_last   = (cnt_q == GAP_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_ack)   state_d = ACK1;
            else if (accept) state_d = host.cmd_rd ? RD : WR;
         end
         WR, RD: if (pulse_last) begin
            state_d = RECOVER;
            cnt_d   = '0;
         end
         RECOVER: state_d = IDLE;
         ACK1: if (pulse_last) begin
            state_d = GAP;
            cnt_d   = '0;
         end
         GAP: if (gap_last) begin
            state_d = ACK2;
            cnt_d   = '0;
         end
         ACK2: if (pulse_last) begin
            state_d = DONE;
            cnt_d   = '0;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin-level outputs are registered from the next state so the PIC never sees decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sync_q      <= 2'b00;
         armed_q     <= 1'b1;
         rd_q        <= 1'b0;
         a0_q        <= 1'b0;
         wdata_q     <= 8'h00;
         rsp_data_q  <= 8'h00;
         vec_data_q  <= 8'h00;
         cs_q        <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         inta_q      <= 1'b1;
         drv_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         vec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= {sync_q[0], INT_Flag};
         if (start_ack)   armed_q <= 1'b0;
         else if (!int_s) armed_q <= 1'b1;
         if (accept) begin
            rd_q    <= host.cmd_rd;
            a0_q    <= host.cmd_a0;
            wdata_q <= host.cmd_data;
         end
         if (state_q == RD && pulse_last)   rsp_data_q <= data_Bus;
         if (state_q == ACK2 && pulse_last) vec_data_q <= data_Bus;
         cs_q        <= !(state_d == WR || state_d == RD);
         rd_n_q      <= (state_d != RD);
         wr_n_q      <= (state_d != WR);
         inta_q      <= !(state_d == ACK1 || state_d == ACK2);
         drv_q       <= (state_d == WR) || (state_d == RECOVER && !rd_q);
         rsp_valid_q <= (state_d == RECOVER) && rd_q;
         vec_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

`ifdef SPURIOUS_DET_EN
   logic spur_q, vec_spur_q;

   // PIC withdrew its request before the second INTA: the vector is the spurious one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spur_q     <= 1'b0;
         vec_spur_q <= 1'b0;
      end else begin
         if (state_q == GAP && gap_last) spur_q <= !int_s;
         vec_spur_q <= (state_d == DONE) && spur_q;
      end
   end

   assign host.vec_spurious = vec_spur_q;
`else
   assign host.vec_spurious = 1'b0;
`endif

   assign chip_select    = cs_q;
   assign read_flag      = rd_n_q;
   assign write_flag     = wr_n_q;
   assign INTA           = inta_q;
   assign A0             = a0_q;
   assign data_Bus       = drv_q ? wdata_q : 8'bz;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign host.vec_valid = vec_valid_q;
   assign host.vec_data  = vec_data_q;
   assign host.busy      = busy_q;

endmodule

// File: tb/tb_pic_host_master.sv
// Randomised bench for pic_host_master with a small PIC bus model; expectations come from
// access/acknowledge timing rules (pulse widths, latencies) and per-transaction data.
module tb_pic_host_master;
   localparam int unsigned P = 2;
   localparam int unsigned G = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pic_host_master_if host ();
   logic       INT_Flag, chip_select, read_flag, write_flag, A0, INTA;
   wire  [7:0] data_Bus;
   logic [7:0] pic_rd_data, pic_vec, probe_val;
   logic       probe_en;

   int vectors = 0;
   int miscompares = 0;

   // PIC drives on read strobe or INTA; probe drives only when the bus should be free.
   assign data_Bus = (!chip_select && !read_flag) ? pic_rd_data :
                     (!INTA ? pic_vec : (probe_en ? probe_val : 8'bz));

   pic_host_master #(.PULSE_W(P), .GAP_W(G)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .host        (host),
      .INT_Flag    (INT_Flag),
      .chip_select (chip_select),
      .read_flag   (read_flag),
      .write_flag  (write_flag),
      .A0          (A0),
      .INTA        (INTA),
      .data_Bus    (data_Bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic probe_bus(input string tag);
      probe_val = 8'h5A;
      probe_en  = 1'b1;
      #1;
      check(tag, {24'h0, data_Bus}, 32'h5A);
      probe_en  = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (host.cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic settle_int();
      INT_Flag = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_write(input bit a0, input logic [7:0] d);
      bit ok;
      int busy_n = 0;
      int low_n  = 0;
      wait_ready(ok);
      check("wr_ready", ok, 1);
      host.cmd_valid = 1'b1;
      host.cmd_rd    = 1'b0;
      host.cmd_a0    = a0;
      host.cmd_data  = d;
      @(negedge clk);
      host.cmd_valid = 1'b0;
      for (int i = 0; i < 20 && host.busy; i++) begin
         busy_n++;
         if (!write_flag) begin
            low_n++;
            check("wr_bus", data_Bus, d);
            check("wr_a0", A0, a0);
            check("wr_cs", chip_select, 0);
         end else begin
            check("wr_hold", data_Bus, d);
         end
         @(negedge clk);
      end
      check("wr_pulse", low_n, P);
      check("wr_lat", busy_n, P + 1);
      check("wr_idle_we", write_flag, 1);
      probe_bus("wr_release");
   endtask

   task automatic do_read(input bit a0, input logic [7:0] d);
      bit ok;
      int busy_n = 0;
      int low_n  = 0;
      int rv_n   = 0;
      int rv_idx = -1;
      int wr_bad = 0;
      pic_rd_data = d;
      wait_ready(ok);
      check("rd_ready", ok, 1);
      host.cmd_valid = 1'b1;
      host.cmd_rd    = 1'b1;
      host.cmd_a0    = a0;
      host.cmd_data  = 8'($urandom);
      @(negedge clk);
      host.cmd_valid = 1'b0;
      for (int i = 0; i < 20 && host.busy; i++) begin
         busy_n++;
         if (!read_flag) begin
            low_n++;
            check("rd_a0", A0, a0);
         end
         if (!write_flag) wr_bad++;
         if (host.rsp_valid) begin
            rv_n++;
            rv_idx = busy_n;
            check("rd_data", host.rsp_data, d);
         end
         @(negedge clk);
      end
      if (host.rsp_valid) rv_n++;
      check("rd_pulse", low_n, P);
      check("rd_lat", busy_n, P + 1);
      check("rd_rsp_cnt", rv_n, 1);
      check("rd_rsp_when", rv_idx, P + 1);
      check("rd_no_wr", wr_bad, 0);
      pic_rd_data = ~d;
      @(negedge clk);
      check("rd_hold", host.rsp_data, d);
      probe_bus("rd_release");
   endtask

   // Negedge index 0 is where INT_Flag rises: two sync stages, then IDLE decides on the next edge.
   task automatic do_ack(input logic [7:0] vec, input bit drop_en, input bit drop_int,
                         input bit keep_int);
      int low_n = 0;
      int first_low = -1;
      int last_low = -1;
      int vv_n = 0;
      int vv_idx = -1;
      int strobe_bad = 0;
      logic spur = 1'b0;
      bit exp_spur;
`ifdef SPURIOUS_DET_EN
      exp_spur = drop_int;
`else
      exp_spur = 1'b0;
`endif
      pic_vec     = vec;
      host.ack_en = 1'b1;
      INT_Flag    = 1'b1;
      for (int n = 1; n <= int'(2 * P + G + 8); n++) begin
         @(negedge clk);
         if (!INTA) begin
            low_n++;
            if (first_low < 0) first_low = n;
            last_low = n;
            if (drop_int && low_n == int'(P)) INT_Flag = 1'b0;
            if (drop_en && low_n == 1) host.ack_en = 1'b0;
         end
         if (!chip_select || !read_flag || !write_flag) strobe_bad++;
         if (host.vec_valid) begin
            vv_n++;
            if (vv_idx < 0) begin
               vv_idx = n;
               spur   = host.vec_spurious;
               check("vec_data", host.vec_data, vec);
            end
         end
      end
      check("ack_start", first_low, 3);
      check("inta_low", low_n, 2 * P);
      check("inta_gap", last_low - first_low + 1 - low_n, G);
      check("vec_lat", vv_idx, 2 * P + G + 3);
      check("vec_pulses", vv_n, 1);
      check("ack_strobes", strobe_bad, 0);
      check("vec_spur", spur, exp_spur);
      check("ack_bus_idle", host.busy, 0);
      if (!keep_int) begin
         settle_int();
         check("vec_hold", host.vec_data, vec);
      end
   endtask

   initial begin
      int cnt, acc, vv;
      bit ok;
      host.cmd_valid = 1'b0;
      host.cmd_rd    = 1'b0;
      host.cmd_a0    = 1'b0;
      host.cmd_data  = 8'h00;
      host.ack_en    = 1'b0;
      INT_Flag       = 1'b0;
      pic_rd_data    = 8'h00;
      pic_vec        = 8'h00;
      probe_val      = 8'h00;
      probe_en       = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_cs", chip_select, 1);
      check("rst_rd", read_flag, 1);
      check("rst_wr", write_flag, 1);
      check("rst_inta", INTA, 1);
      check("rst_ready", host.cmd_ready, 0);
      check("rst_flags", {host.rsp_valid, host.vec_valid, host.vec_spurious, host.busy}, 0);
      check("rst_rsp", host.rsp_data, 0);
      check("rst_vec", host.vec_data, 0);
      probe_bus("rst_bus");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_write(1'b0, 8'h13);
      do_read(1'b1, 8'hFB);

      // Level stays high after the acknowledge: no re-acknowledge until it has been seen low.
      do_ack(8'h0A, 1'b0, 1'b0, 1'b1);
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (!INTA || host.busy) cnt++;
      end
      check("no_reack", cnt, 0);
      check("ready_unarmed", host.cmd_ready, 1);
      settle_int();
      do_ack(8'h21, 1'b0, 1'b0, 1'b0);

      // Interrupt and command pending together: acknowledge wins, command follows DONE.
      host.ack_en = 1'b1;
      pic_vec     = 8'h5C;
      INT_Flag    = 1'b1;
      repeat (2) @(negedge clk);
      check("prio_ready", host.cmd_ready, 0);
      host.cmd_valid = 1'b1;
      host.cmd_rd    = 1'b0;
      host.cmd_a0    = 1'b1;
      host.cmd_data  = 8'h3C;
      acc = -1;
      vv  = -1;
      for (int n = 2; n < 40; n++) begin
         if (host.vec_valid && vv < 0) vv = n;
         if (host.cmd_valid && host.cmd_ready && acc < 0) acc = n;
         @(negedge clk);
         if (acc >= 0) host.cmd_valid = 1'b0;
      end
      check("prio_vec", vv, 2 * P + G + 3);
      check("prio_acc", acc, 2 * P + G + 4);
      settle_int();

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: do_write(1'($urandom), 8'($urandom));
            1: do_read(1'($urandom), 8'($urandom));
            2: do_ack(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            default: begin
               host.ack_en = 1'b0;
               INT_Flag    = 1'b1;
               cnt = 0;
               repeat (8) begin
                  @(negedge clk);
                  if (!INTA || host.busy) cnt++;
               end
               check("ack_gate", cnt, 0);
               settle_int();
            end
         endcase
      end

      do_ack(8'h44, 1'b0, 1'b1, 1'b0);

      // Reset asserted inside ACK2 must drop INTA at once and lose the vector.
      host.ack_en = 1'b1;
      pic_vec     = 8'h77;
      INT_Flag    = 1'b1;
      cnt = 0;
      ok  = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (!INTA) cnt++;
         if (cnt == int'(P + 1)) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack2_reached", ok, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_inta", INTA, 1);
      check("rst_mid_busy", host.busy, 0);
      check("rst_mid_vec", host.vec_data, 0);
      INT_Flag = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (host.vec_valid || !INTA) cnt++;
      end
      check("rst_mid_novec", cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);
      do_write(1'($urandom), 8'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
